pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the IF/ID/EX pipeline.
- Generates per-stage enable and squash (stage_ena_*, stage_x_*), plus the PC redirect pair (take_new_pc, pc_new) consumed by the fetch stage.
- Handles boot fill, data-memory wait freeze with timeout, EX branch-misprediction flush, load-use bubble insertion, decode jumps and fetch predicted-taken redirects.

Parameters:
- BOOT_CYCLES, 3: cycles after reset release during which bubbles are injected into ID/EX.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before the block halts. Must be 1..65535.
- CNT_W, 16: width of the internal wait counter.

Ports:
- stage_clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_req  in  1  data-memory access pending in EX
- mem_ready  in  1  data memory completes this cycle
- br_valid_ex  in  1  conditional branch resolved in EX this cycle
- br_taken_ex  in  1  actual branch outcome
- br_pred_ex  in  1  prediction that travelled with the branch
- br_target_ex  in  32  branch target
- pc_ex  in  32  PC of the EX instruction
- lu_hazard_dec  in  1  decode instruction depends on the load in EX
- jump_dec  in  1  unconditional jump decoded
- jump_target_dec  in  32  jump target
- pred_taken_if  in  1  predictor says taken for the fetched instruction
- pred_target_if  in  32  predicted target
- stage_ena_if, stage_ena_id, stage_ena_ex  out  1 each  stage enables
- stage_x_if, stage_x_id, stage_x_ex  out  1 each  squash: load NOP into the stage's output register
- take_new_pc  out  1  fetch uses pc_new
- pc_new  out  32  redirect PC
- halted  out  1  registered; memory timeout occurred
- mem_timeout  out  1  registered sticky error flag

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT, HALT. State and counter are registered. All stage_* outputs, take_new_pc and pc_new are combinational from state and inputs (same-cycle effect on the fetch stage).
- Invariant: whenever stage_x_* = 1, the matching stage_ena_* = 1. The fetch stage still advances its PC via pc_next.
- Reset, asynchronous: state=BOOT, counter=0, halted=0, mem_timeout=0.
  - Reset-state outputs: stage_ena_* = 1, stage_x_if=0, stage_x_id=1, stage_x_ex=1, take_new_pc=0, pc_new=0.
  - Reset asserted mid-operation behaves the same regardless of state.
- BOOT:
  - Outputs: ena all 1, stage_x_id=stage_x_ex=1, stage_x_if=0, no redirect. All other inputs are ignored.
  - Counter increments each cycle; on counter==BOOT_CYCLES-1, go to RUN and clear the counter.
- RUN: evaluate in priority order; first match wins.
  1. mem_req && !mem_ready: all ena=0, all x=0, no redirect; next state MEM_WAIT, counter=1.
  2. Mispredict (br_valid_ex && br_taken_ex != br_pred_ex): take_new_pc=1; pc_new = br_taken_ex ? br_target_ex : pc_ex+4 (32-bit wrap); stage_x_if=1, stage_x_id=1; all ena=1.
  3. lu_hazard_dec: stage_ena_if=0, stage_ena_id=0, stage_ena_ex=1, stage_x_ex=1; no redirect (fetch holds its PC).
  4. jump_dec: take_new_pc=1, pc_new=jump_target_dec, stage_x_if=1, all ena=1.
  5. pred_taken_if: take_new_pc=1, pc_new=pred_target_if, no squash, all ena=1.
  6. Otherwise: all ena=1, all x=0, take_new_pc=0, pc_new=0.
- MEM_WAIT:
  - Outputs: all ena=0, x=0, no redirect; all other inputs are ignored.
  - If mem_ready: next state RUN, counter=0. The stalled branch or hazard re-evaluates next cycle.
  - Else if counter==MEM_TIMEOUT: next state HALT, mem_timeout<=1, halted<=1.
  - Else: counter increments, saturating at its maximum.
- HALT: all ena=0, x=0, no redirect. Exit only via reset.
- Outputs in BOOT/MEM_WAIT/HALT: pc_new=0 whenever take_new_pc=0.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- When defined: adds output ports cnt_mispredict[31:0] and cnt_stall[31:0], both reset to 0.
  - cnt_mispredict increments once per RUN cycle in which rule 2 fires.
  - cnt_stall increments once per cycle spent in MEM_WAIT and per RUN cycle in which rule 3 fires.
  - Both wrap modulo 2^32.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Boot: release reset with BOOT_CYCLES=3 → stage_x_id=stage_x_ex=1 for exactly 3 cycles; RUN on cycle 4 with all x=0 and all ena=1.
- Mispredict: br_valid_ex=1, br_taken_ex=0, br_pred_ex=1, pc_ex=0x100 → same cycle take_new_pc=1, pc_new=0x104, stage_x_if=stage_x_id=1. Variant with taken=1, pred=0, target=0x40 → pc_new=0x40.
- Priority: lu_hazard_dec=1, jump_dec=1 and a mispredict in the same cycle → mispredict response only. With mispredict removed → stage_ena_if=stage_ena_id=0, stage_x_ex=1, take_new_pc=0.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles, then ready → all ena=0 for 6 cycles (RUN entry plus 5 MEM_WAIT), back to RUN; mem_timeout stays 0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → halted=mem_timeout=1 after 5 stall cycles. Outputs stay frozen while other inputs toggle. Reset asserted mid-HALT → returns to BOOT with flags cleared.
- With PIPE_CTRL_PERF_CNT_EN: 2 mispredicts plus a 3-cycle memory wait → cnt_mispredict=2, cnt_stall=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for a three-stage IF/ID/EX pipeline. It produces the
// per-stage enable and squash controls and the PC redirect consumed by the
// fetch stage. It covers:
//   * boot fill: bubbles go into ID/EX for BOOT_CYCLES cycles after reset
//   * data-memory wait freeze, with a timeout that halts the block
//   * EX branch-misprediction flush
//   * load-use bubble insertion
//   * decode jumps and fetch predicted-taken redirects
//
// Parameters:
//   BOOT_CYCLES  bubble-injection cycles after reset release (>= 1)
//   MEM_TIMEOUT  consecutive MEM_WAIT cycles tolerated before halting (1..65535)
//   CNT_W        width of the internal boot/wait counter
//
// Ports:
//   stage_clk, reset            clock (rising edge) and asynchronous active-high reset
//   mem_req, mem_ready          data-memory handshake of the EX stage
//   br_*_ex, pc_ex              branch resolution information from EX
//   lu_hazard_dec               decode instruction depends on the load in EX
//   jump_dec, jump_target_dec   unconditional jump decoded in ID
//   pred_taken_if, pred_target_if  fetch-stage predictor
//   stage_ena_{if,id,ex}        stage enables
//   stage_x_{if,id,ex}          squash: load a NOP into the stage's output register
//   take_new_pc, pc_new         redirect request to fetch
//   halted, mem_timeout         registered; set when a memory wait times out
//
// Optional feature (macro PIPE_CTRL_PERF_CNT_EN):
//   Adds the 32-bit wrapping counters cnt_mispredict and cnt_stall.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic        stage_clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        br_valid_ex,
    input  logic        br_taken_ex,
    input  logic        br_pred_ex,
    input  logic [31:0] br_target_ex,
    input  logic [31:0] pc_ex,
    input  logic        lu_hazard_dec,
    input  logic        jump_dec,
    input  logic [31:0] jump_target_dec,
    input  logic        pred_taken_if,
    input  logic [31:0] pred_target_if,
    output logic        stage_ena_if,
    output logic        stage_ena_id,
    output logic        stage_ena_ex,
    output logic        stage_x_if,
    output logic        stage_x_id,
    output logic        stage_x_ex,
    output logic        take_new_pc,
    output logic [31:0] pc_new,
    output logic        halted,
    output logic        mem_timeout
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cnt_mispredict,
    output logic [31:0] cnt_stall
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] BOOT_LAST   = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             mem_timeout_q, mem_timeout_d;

    // A stalled memory access in EX and a resolved-wrong branch in EX.
    logic mem_stall;
    logic mispredict;

    assign mem_stall  = mem_req && !mem_ready;
    assign mispredict = br_valid_ex && (br_taken_ex != br_pred_ex);

    // Next-state and output logic.
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        halted_d      = halted_q;
        mem_timeout_d = mem_timeout_q;

        stage_ena_if  = 1'b0;
        stage_ena_id  = 1'b0;
        stage_ena_ex  = 1'b0;
        stage_x_if    = 1'b0;
        stage_x_id    = 1'b0;
        stage_x_ex    = 1'b0;
        take_new_pc   = 1'b0;
        pc_new        = 32'h0;

        unique case (state_q)
            ST_BOOT: begin
                // Pipeline runs, but ID and EX receive bubbles until the fill ends.
                stage_ena_if = 1'b1;
                stage_ena_id = 1'b1;
                stage_ena_ex = 1'b1;
                stage_x_id   = 1'b1;
                stage_x_ex   = 1'b1;
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (mem_stall) begin
                    // Freeze everything; the wait cycle being entered is counted as 1.
                    state_d = ST_MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (mispredict) begin
                    // Flush the two younger instructions and restart fetch.
                    stage_ena_if = 1'b1;
                    stage_ena_id = 1'b1;
                    stage_ena_ex = 1'b1;
                    stage_x_if   = 1'b1;
                    stage_x_id   = 1'b1;
                    take_new_pc  = 1'b1;
                    pc_new       = br_taken_ex ? br_target_ex : (pc_ex + 32'd4);
                end else if (lu_hazard_dec) begin
                    // Hold IF/ID and push a bubble into EX so the load can complete.
                    stage_ena_ex = 1'b1;
                    stage_x_ex   = 1'b1;
                end else if (jump_dec) begin
                    // The instruction fetched behind the jump is on the wrong path.
                    stage_ena_if = 1'b1;
                    stage_ena_id = 1'b1;
                    stage_ena_ex = 1'b1;
                    stage_x_if   = 1'b1;
                    take_new_pc  = 1'b1;
                    pc_new       = jump_target_dec;
                end else if (pred_taken_if) begin
                    stage_ena_if = 1'b1;
                    stage_ena_id = 1'b1;
                    stage_ena_ex = 1'b1;
                    take_new_pc  = 1'b1;
                    pc_new       = pred_target_if;
                end else begin
                    stage_ena_if = 1'b1;
                    stage_ena_id = 1'b1;
                    stage_ena_ex = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Outputs stay frozen at their defaults; only the wait is tracked.
                if (mem_ready) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d       = ST_HALT;
                    halted_d      = 1'b1;
                    mem_timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_HALT: begin
                // Terminal until reset.
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            cnt_q         <= '0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign halted      = halted_q;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Rule firings mirror the RUN priority chain above.
    logic        perf_mispredict;
    logic        perf_stall;
    logic [31:0] cnt_mispredict_q, cnt_mispredict_d;
    logic [31:0] cnt_stall_q, cnt_stall_d;

    assign perf_mispredict = (state_q == ST_RUN) && !mem_stall && mispredict;
    assign perf_stall      = (state_q == ST_MEM_WAIT) ||
                             ((state_q == ST_RUN) && !mem_stall && !mispredict &&
                              lu_hazard_dec);

    always_comb begin
        cnt_mispredict_d = cnt_mispredict_q;
        cnt_stall_d      = cnt_stall_q;
        if (perf_mispredict) cnt_mispredict_d = cnt_mispredict_q + 32'd1;
        if (perf_stall)      cnt_stall_d      = cnt_stall_q + 32'd1;
    end

    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            cnt_mispredict_q <= 32'd0;
            cnt_stall_q      <= 32'd0;
        end else begin
            cnt_mispredict_q <= cnt_mispredict_d;
            cnt_stall_q      <= cnt_stall_d;
        end
    end

    assign cnt_mispredict = cnt_mispredict_q;
    assign cnt_stall      = cnt_stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Two instances share every input:
//   dut_a  MEM_TIMEOUT=255  (normal memory-wait behaviour)
//   dut_b  MEM_TIMEOUT=4    (times out during the same wait sequence)
// Control outputs are packed as {ena_if, ena_id, ena_ex, x_if, x_id, x_ex, take_new_pc}.
// With PIPE_CTRL_PERF_CNT_EN defined the performance counters are checked too.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        stage_clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_ready;
    logic        br_valid_ex, br_taken_ex, br_pred_ex;
    logic [31:0] br_target_ex, pc_ex;
    logic        lu_hazard_dec, jump_dec;
    logic [31:0] jump_target_dec;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;

    logic        ena_if_a, ena_id_a, ena_ex_a, x_if_a, x_id_a, x_ex_a, take_a;
    logic [31:0] pc_new_a;
    logic        halted_a, timeout_a;
    logic        ena_if_b, ena_id_b, ena_ex_b, x_if_b, x_id_b, x_ex_b, take_b;
    logic [31:0] pc_new_b;
    logic        halted_b, timeout_b;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] cnt_mis_a, cnt_stall_a, cnt_mis_b, cnt_stall_b;
`endif

    logic [6:0] ctl_a, ctl_b;
    assign ctl_a = {ena_if_a, ena_id_a, ena_ex_a, x_if_a, x_id_a, x_ex_a, take_a};
    assign ctl_b = {ena_if_b, ena_id_b, ena_ex_b, x_if_b, x_id_b, x_ex_b, take_b};

    localparam logic [6:0] C_BOOT  = 7'b111_011_0;
    localparam logic [6:0] C_RUN   = 7'b111_000_0;
    localparam logic [6:0] C_STALL = 7'b000_000_0;
    localparam logic [6:0] C_MISP  = 7'b111_110_1;
    localparam logic [6:0] C_LU    = 7'b001_001_0;
    localparam logic [6:0] C_JUMP  = 7'b111_100_1;
    localparam logic [6:0] C_PRED  = 7'b111_000_1;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 stage_clk = ~stage_clk;

    pipe_hazard_ctrl #(.BOOT_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .stage_clk(stage_clk), .reset(reset),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .br_valid_ex(br_valid_ex), .br_taken_ex(br_taken_ex), .br_pred_ex(br_pred_ex),
        .br_target_ex(br_target_ex), .pc_ex(pc_ex),
        .lu_hazard_dec(lu_hazard_dec), .jump_dec(jump_dec), .jump_target_dec(jump_target_dec),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .stage_ena_if(ena_if_a), .stage_ena_id(ena_id_a), .stage_ena_ex(ena_ex_a),
        .stage_x_if(x_if_a), .stage_x_id(x_id_a), .stage_x_ex(x_ex_a),
        .take_new_pc(take_a), .pc_new(pc_new_a),
        .halted(halted_a), .mem_timeout(timeout_a)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .cnt_mispredict(cnt_mis_a), .cnt_stall(cnt_stall_a)
`endif
    );

    pipe_hazard_ctrl #(.BOOT_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut_b (
        .stage_clk(stage_clk), .reset(reset),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .br_valid_ex(br_valid_ex), .br_taken_ex(br_taken_ex), .br_pred_ex(br_pred_ex),
        .br_target_ex(br_target_ex), .pc_ex(pc_ex),
        .lu_hazard_dec(lu_hazard_dec), .jump_dec(jump_dec), .jump_target_dec(jump_target_dec),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .stage_ena_if(ena_if_b), .stage_ena_id(ena_id_b), .stage_ena_ex(ena_ex_b),
        .stage_x_if(x_if_b), .stage_x_id(x_id_b), .stage_x_ex(x_ex_b),
        .take_new_pc(take_b), .pc_new(pc_new_b),
        .halted(halted_b), .mem_timeout(timeout_b)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .cnt_mispredict(cnt_mis_b), .cnt_stall(cnt_stall_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        br_valid_ex     = 1'b0;
        br_taken_ex     = 1'b0;
        br_pred_ex      = 1'b0;
        br_target_ex    = 32'h0;
        pc_ex           = 32'h0;
        lu_hazard_dec   = 1'b0;
        jump_dec        = 1'b0;
        jump_target_dec = 32'h0;
        pred_taken_if   = 1'b0;
        pred_target_if  = 32'h0;
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic nxt();
        @(negedge stage_clk);
    endtask

    initial begin
        // ---------------- reset state, with redirect-type inputs asserted ----
        reset = 1'b1;
        clr_inputs();
        jump_dec        = 1'b1;
        jump_target_dec = 32'hDEAD_0000;
        pred_taken_if   = 1'b1;
        pred_target_if  = 32'hBEEF_0000;
        #2;
        check("rst_ctl_a", ctl_a, C_BOOT);
        check("rst_pc_a", pc_new_a, 32'h0);
        check("rst_halted_a", halted_a, 1'b0);
        check("rst_timeout_a", timeout_a, 1'b0);
        check("rst_ctl_b", ctl_b, C_BOOT);

        // ---------------- boot fill: exactly three bubble cycles -------------
        nxt(); reset = 1'b0;
        #1 check("boot1_ctl", ctl_a, C_BOOT);
        check("boot1_pc", pc_new_a, 32'h0);
        nxt();
        #1 check("boot2_ctl", ctl_a, C_BOOT);
        nxt(); clr_inputs();
        #1 check("boot3_ctl", ctl_a, C_BOOT);
        nxt();
        #1 check("run_ctl_a", ctl_a, C_RUN);
        check("run_pc_a", pc_new_a, 32'h0);
        check("run_ctl_b", ctl_b, C_RUN);

        // ---------------- mispredicts ----------------------------------------
        nxt();
        br_valid_ex = 1'b1; br_taken_ex = 1'b0; br_pred_ex = 1'b1;
        pc_ex = 32'h0000_0100; br_target_ex = 32'h0000_0040;
        #1 check("misp_nt_ctl", ctl_a, C_MISP);
        check("misp_nt_pc", pc_new_a, 32'h0000_0104);
        nxt();
        br_taken_ex = 1'b1; br_pred_ex = 1'b0;
        #1 check("misp_t_ctl", ctl_a, C_MISP);
        check("misp_t_pc", pc_new_a, 32'h0000_0040);
        nxt();
        br_taken_ex = 1'b0; br_pred_ex = 1'b1; pc_ex = 32'hFFFF_FFFC;
        #1 check("misp_wrap_pc", pc_new_a, 32'h0000_0000);
        nxt();
        br_taken_ex = 1'b1; br_pred_ex = 1'b1;
        #1 check("br_correct_ctl", ctl_a, C_RUN);
        check("br_correct_pc", pc_new_a, 32'h0);

        // ---------------- priority chain -------------------------------------
        nxt();
        br_taken_ex = 1'b0; br_pred_ex = 1'b1; pc_ex = 32'h0000_0100;
        lu_hazard_dec = 1'b1; jump_dec = 1'b1; jump_target_dec = 32'h0000_3000;
        pred_taken_if = 1'b1; pred_target_if = 32'h0000_2000;
        #1 check("prio_misp_ctl", ctl_a, C_MISP);
        check("prio_misp_pc", pc_new_a, 32'h0000_0104);
        nxt(); br_valid_ex = 1'b0;
        #1 check("prio_lu_ctl", ctl_a, C_LU);
        check("prio_lu_pc", pc_new_a, 32'h0);
        nxt(); lu_hazard_dec = 1'b0;
        #1 check("prio_jump_ctl", ctl_a, C_JUMP);
        check("prio_jump_pc", pc_new_a, 32'h0000_3000);
        nxt(); jump_dec = 1'b0;
        #1 check("prio_pred_ctl", ctl_a, C_PRED);
        check("prio_pred_pc", pc_new_a, 32'h0000_2000);
        nxt(); clr_inputs();
        #1 check("idle_ctl", ctl_a, C_RUN);

        // ---------------- memory wait (a) and timeout (b) --------------------
        // Five not-ready cycles: RUN entry + four MEM_WAIT. dut_b reaches its
        // count of 4 on the last of them and halts at the following edge.
        nxt();
        mem_req = 1'b1; mem_ready = 1'b0;
        br_valid_ex = 1'b1; br_taken_ex = 1'b1; br_pred_ex = 1'b0; br_target_ex = 32'h40;
        for (int i = 0; i < 5; i++) begin
            #1 check("wait_ctl_a", ctl_a, C_STALL);
            check("wait_pc_a", pc_new_a, 32'h0);
            check("wait_halted_b", halted_b, 1'b0);
            nxt();
        end
        mem_ready = 1'b1;
        #1 check("wait6_ctl_a", ctl_a, C_STALL);
        check("halted_b", halted_b, 1'b1);
        check("timeout_b", timeout_b, 1'b1);
        check("no_timeout_a", timeout_a, 1'b0);
        nxt(); clr_inputs();
        #1 check("resume_ctl_a", ctl_a, C_RUN);
        check("resume_timeout_a", timeout_a, 1'b0);
        check("resume_halted_a", halted_a, 1'b0);
        check("halt_ctl_b", ctl_b, C_STALL);

        // ---------------- HALT ignores inputs --------------------------------
        nxt();
        jump_dec = 1'b1; jump_target_dec = 32'h123;
        br_valid_ex = 1'b1; br_taken_ex = 1'b1; br_pred_ex = 1'b0; br_target_ex = 32'h40;
        #1 check("halt_frozen_ctl_b", ctl_b, C_STALL);
        check("halt_frozen_pc_b", pc_new_b, 32'h0);
        check("run_misp_ctl_a", ctl_a, C_MISP);
        nxt(); br_valid_ex = 1'b0; mem_req = 1'b1; mem_ready = 1'b1;
        #1 check("halt_frozen2_ctl_b", ctl_b, C_STALL);
        check("halt_sticky_b", halted_b, 1'b1);

        // ---------------- reset asserted mid-HALT ----------------------------
        nxt(); clr_inputs(); reset = 1'b1;
        #1 check("rst2_ctl_b", ctl_b, C_BOOT);
        check("rst2_halted_b", halted_b, 1'b0);
        check("rst2_timeout_b", timeout_b, 1'b0);
        check("rst2_ctl_a", ctl_a, C_BOOT);
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("rst2_cnt_mis_a", cnt_mis_a, 32'd0);
        check("rst2_cnt_stall_a", cnt_stall_a, 32'd0);
`endif
        nxt(); reset = 1'b0;
        #1 check("reboot1_ctl_b", ctl_b, C_BOOT);
        nxt();
        #1 check("reboot2_ctl_b", ctl_b, C_BOOT);
        nxt();
        #1 check("reboot3_ctl_b", ctl_b, C_BOOT);
        nxt();
        #1 check("rerun_ctl_b", ctl_b, C_RUN);

`ifdef PIPE_CTRL_PERF_CNT_EN
        // ---------------- performance counters -------------------------------
        // Two mispredict cycles, then RUN stall entry + three MEM_WAIT cycles.
        nxt();
        br_valid_ex = 1'b1; br_taken_ex = 1'b0; br_pred_ex = 1'b1; pc_ex = 32'h100;
        nxt();
        br_taken_ex = 1'b1; br_pred_ex = 1'b0;
        nxt(); clr_inputs();
        mem_req = 1'b1;
        nxt();
        nxt();
        nxt(); mem_ready = 1'b1;
        nxt(); clr_inputs();
        #1 check("perf_ctl_a", ctl_a, C_RUN);
        check("perf_cnt_mis_a", cnt_mis_a, 32'd2);
        check("perf_cnt_stall_a", cnt_stall_a, 32'd3);
        check("perf_cnt_stall_b", cnt_stall_b, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
